// File: rtl/conveyor_write_arbiter.sv
// Conveyor slot-write arbiter: one result buffer per producer, round-robin grant onto the single
// conveyor write port, yielding to conveyor control (wr_block) and honouring per-conveyor flush.
module conveyor_write_arbiter #(
    parameter int unsigned  WORD_WIDTH          = 32,
    parameter int unsigned  CONVEYOR_ADDR_WIDTH = 4,
    parameter int unsigned  REQUESTERS          = 4,
    localparam int unsigned FAULT_ADDR_WIDTH    = 3
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [REQUESTERS-1:0]                     req_valid,
    output logic [REQUESTERS-1:0]                     req_ready,
    input  logic [REQUESTERS-1:0]                     req_conveyor,
    input  logic [REQUESTERS*CONVEYOR_ADDR_WIDTH-1:0] req_addr,
    input  logic [REQUESTERS*WORD_WIDTH-1:0]          req_value,
    input  logic [REQUESTERS*FAULT_ADDR_WIDTH-1:0]    req_fault,
    input  logic                                      wr_block,
    input  logic [1:0]                                flush,
    output logic                                      wr_en,
    output logic                                      wr_conveyor,
    output logic [CONVEYOR_ADDR_WIDTH-1:0]            wr_addr,
    output logic [WORD_WIDTH-1:0]                     wr_value,
    output logic [FAULT_ADDR_WIDTH-1:0]               wr_fault,
    output logic [15:0]                               stall_count
);

    localparam int unsigned PtrWidth = $clog2(REQUESTERS);

    logic [REQUESTERS-1:0]          buf_valid_q, buf_valid_d;
    logic [REQUESTERS-1:0]          buf_conv_q, buf_conv_d;
    logic [CONVEYOR_ADDR_WIDTH-1:0] buf_addr_q  [REQUESTERS];
    logic [CONVEYOR_ADDR_WIDTH-1:0] buf_addr_d  [REQUESTERS];
    logic [WORD_WIDTH-1:0]          buf_value_q [REQUESTERS];
    logic [WORD_WIDTH-1:0]          buf_value_d [REQUESTERS];
    logic [FAULT_ADDR_WIDTH-1:0]    buf_fault_q [REQUESTERS];
    logic [FAULT_ADDR_WIDTH-1:0]    buf_fault_d [REQUESTERS];
    logic [PtrWidth-1:0]            rr_q, rr_d;
    logic [15:0]                    stall_q, stall_d;

    logic [REQUESTERS-1:0] eligible;
    logic                  any_eligible;
    logic                  grant_found;
    logic [PtrWidth-1:0]   grant_idx;
    logic [PtrWidth-1:0]   cand;

    // Eligibility and handshake; req_ready depends only on state and reset.
    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            eligible[i] = buf_valid_q[i] && !flush[buf_conv_q[i]];
        end
        any_eligible = |eligible;
        req_ready    = ~buf_valid_q & {REQUESTERS{~reset}};
    end

    // Round-robin search upward from rr_q with wrap; first eligible entry wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            cand = PtrWidth'((32'(rr_q) + 32'(k)) % REQUESTERS);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Write port; fields follow the granted entry (entry 0 when nothing is eligible).
    always_comb begin
        wr_en       = any_eligible && !wr_block && !reset;
        wr_conveyor = buf_conv_q[grant_idx];
        wr_addr     = buf_addr_q[grant_idx];
        wr_value    = buf_value_q[grant_idx];
        wr_fault    = buf_fault_q[grant_idx];
        stall_count = stall_q;
    end

    // Next state: flush clears, grant releases, accept loads (dropped if its conveyor is flushed).
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_conv_d  = buf_conv_q;
        buf_addr_d  = buf_addr_q;
        buf_value_d = buf_value_q;
        buf_fault_d = buf_fault_q;
        rr_d        = rr_q;
        stall_d     = stall_q;

        for (int i = 0; i < REQUESTERS; i++) begin
            if (buf_valid_q[i] && flush[buf_conv_q[i]]) begin
                buf_valid_d[i] = 1'b0;
            end
        end

        if (wr_en) begin
            buf_valid_d[grant_idx] = 1'b0;
            rr_d = (grant_idx == PtrWidth'(REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
        end

        // Accepting entries are empty, so this never collides with the grant release above.
        for (int i = 0; i < REQUESTERS; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                buf_valid_d[i] = !flush[req_conveyor[i]];
                buf_conv_d[i]  = req_conveyor[i];
                buf_addr_d[i]  = req_addr[i*CONVEYOR_ADDR_WIDTH +: CONVEYOR_ADDR_WIDTH];
                buf_value_d[i] = req_value[i*WORD_WIDTH +: WORD_WIDTH];
                buf_fault_d[i] = req_fault[i*FAULT_ADDR_WIDTH +: FAULT_ADDR_WIDTH];
            end
        end

        if (any_eligible && wr_block && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= '0;
            rr_q        <= '0;
            stall_q     <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            rr_q        <= rr_d;
            stall_q     <= stall_d;
        end
    end

    // Payload storage; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        buf_conv_q  <= buf_conv_d;
        buf_addr_q  <= buf_addr_d;
        buf_value_q <= buf_value_d;
        buf_fault_q <= buf_fault_d;
    end

endmodule

// File: tb/tb_conveyor_write_arbiter.sv
// Directed bench for conveyor_write_arbiter: expected writes are queued as stimulus is driven and
// compared by a monitor whenever wr_en is seen at the falling edge.
module tb_conveyor_write_arbiter;

    localparam int R  = 4;
    localparam int AW = 4;
    localparam int WW = 32;
    localparam int FW = 3;

    typedef struct packed {
        logic          conv;
        logic [FW-1:0] fault;
        logic [AW-1:0] addr;
        logic [WW-1:0] value;
    } wr_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [R-1:0]    req_valid;
    logic [R-1:0]    req_ready;
    logic [R-1:0]    req_conveyor;
    logic [R*AW-1:0] req_addr;
    logic [R*WW-1:0] req_value;
    logic [R*FW-1:0] req_fault;
    logic            wr_block;
    logic [1:0]      flush;
    logic            wr_en;
    logic            wr_conveyor;
    logic [AW-1:0]   wr_addr;
    logic [WW-1:0]   wr_value;
    logic [FW-1:0]   wr_fault;
    logic [15:0]     stall_count;

    int  tests = 0;
    int  fails = 0;
    wr_t exp_q[$];

    conveyor_write_arbiter #(
        .WORD_WIDTH          (WW),
        .CONVEYOR_ADDR_WIDTH (AW),
        .REQUESTERS          (R)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_conveyor (req_conveyor),
        .req_addr     (req_addr),
        .req_value    (req_value),
        .req_fault    (req_fault),
        .wr_block     (wr_block),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_conveyor  (wr_conveyor),
        .wr_addr      (wr_addr),
        .wr_value     (wr_value),
        .wr_fault     (wr_fault),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic c, input logic [AW-1:0] a,
                           input logic [WW-1:0] v, input logic [FW-1:0] f);
        req_valid[i]            = 1'b1;
        req_conveyor[i]         = c;
        req_addr[i*AW +: AW]    = a;
        req_value[i*WW +: WW]   = v;
        req_fault[i*FW +: FW]   = f;
    endtask

    task automatic push_exp(input logic c, input logic [AW-1:0] a, input logic [WW-1:0] v,
                            input logic [FW-1:0] f);
        wr_t e;
        e.conv  = c;
        e.addr  = a;
        e.value = v;
        e.fault = f;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {wr_conveyor, wr_fault, wr_addr, wr_value}, 64'hX);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_fields", {wr_conveyor, wr_fault, wr_addr, wr_value}, e);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_conveyor = '0;
        req_addr     = '0;
        req_value    = '0;
        req_fault    = '0;
        wr_block     = 1'b0;
        flush        = 2'b00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_ready", req_ready, 0);
        next_edge();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 4'hF);
        check("post_rst_wr_en", wr_en, 0);
        check("post_rst_stall", stall_count, 0);

        // Round-robin burst from rr_ptr=0, then a repeat burst
        for (int b = 0; b < 2; b++) begin
            next_edge();
            for (int i = 0; i < R; i++) begin
                set_req(i, 1'b0, AW'(i), 32'h1000 * (b + 1) + 32'(i), '0);
                push_exp(1'b0, AW'(i), 32'h1000 * (b + 1) + 32'(i), '0);
            end
            next_edge();
            req_valid = '0;
            for (int k = 0; k < R; k++) begin
                @(negedge clk);
                check("rr_wr_en", wr_en, 1);
                next_edge();
            end
            @(negedge clk);
            check("rr_idle", wr_en, 0);
            check("rr_drain", exp_q.size(), 0);
        end

        // Producers 1 and 3 after a grant to 3: order 1 then 3
        next_edge();
        set_req(3, 1'b0, 4'd13, 32'h0000_3333, '0);
        set_req(1, 1'b0, 4'd11, 32'h0000_1111, '0);
        push_exp(1'b0, 4'd11, 32'h0000_1111, '0);
        push_exp(1'b0, 4'd13, 32'h0000_3333, '0);
        next_edge();
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("pair_drain", exp_q.size(), 0);

        // Single write from producer 2
        next_edge();
        set_req(2, 1'b0, 4'd5, 32'hDEADBEEF, '0);
        push_exp(1'b0, 4'd5, 32'hDEADBEEF, '0);
        @(negedge clk);
        check("single_ready_before", req_ready, 4'hF);
        next_edge();
        req_valid = '0;
        @(negedge clk);
        check("single_wr_en", wr_en, 1);
        check("single_ready_busy", req_ready, 4'b1011);
        next_edge();
        @(negedge clk);
        check("single_ready_back", req_ready, 4'hF);
        check("single_idle", wr_en, 0);
        check("single_drain", exp_q.size(), 0);

        // wr_block for 3 cycles with producer 0 pending
        next_edge();
        set_req(0, 1'b0, 4'd6, 32'h0BAD_F00D, '0);
        push_exp(1'b0, 4'd6, 32'h0BAD_F00D, '0);
        next_edge();
        req_valid = '0;
        wr_block  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("block_wr_en", wr_en, 0);
            next_edge();
        end
        wr_block = 1'b0;
        @(negedge clk);
        check("block_stall", stall_count, 3);
        check("block_release_wr_en", wr_en, 1);
        next_edge();
        @(negedge clk);
        check("block_drain", exp_q.size(), 0);

        // Flush conveyor 1: only producer 2 (conveyor 0) is written, producer 3 accept dropped
        next_edge();
        wr_block = 1'b1;
        set_req(0, 1'b1, 4'd1, 32'hAAAA_0000, '0);
        set_req(1, 1'b1, 4'd2, 32'hAAAA_0001, '0);
        set_req(2, 1'b0, 4'd3, 32'hBBBB_0002, '0);
        push_exp(1'b0, 4'd3, 32'hBBBB_0002, '0);
        next_edge();
        req_valid = '0;
        wr_block  = 1'b0;
        flush     = 2'b10;
        set_req(3, 1'b1, 4'd4, 32'hCCCC_0003, '0);
        @(negedge clk);
        check("flush_wr_en", wr_en, 1);
        check("flush_ready3", req_ready[3], 1);
        next_edge();
        flush     = 2'b00;
        req_valid = '0;
        @(negedge clk);
        check("flush_idle", wr_en, 0);
        check("flush_ready", req_ready, 4'hF);
        repeat (2) @(negedge clk);
        check("flush_drain", exp_q.size(), 0);

        // Reset with 3 entries pending
        next_edge();
        wr_block = 1'b1;
        set_req(0, 1'b0, 4'd8, 32'h1, '0);
        set_req(1, 1'b0, 4'd9, 32'h2, '0);
        set_req(2, 1'b1, 4'd10, 32'h3, '0);
        next_edge();
        req_valid = '0;
        wr_block  = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_ready", req_ready, 0);
        next_edge();
        reset = 1'b0;
        @(negedge clk);
        check("after_rst_wr_en", wr_en, 0);
        check("after_rst_ready", req_ready, 4'hF);
        check("after_rst_stall", stall_count, 0);
        repeat (2) @(negedge clk);
        check("after_rst_idle", wr_en, 0);

        // Fault passthrough
        next_edge();
        set_req(1, 1'b1, 4'd9, 32'hCAFE_0001, 3'd2);
        push_exp(1'b1, 4'd9, 32'hCAFE_0001, 3'd2);
        next_edge();
        req_valid = '0;
        @(negedge clk);
        check("fault_wr_en", wr_en, 1);
        check("fault_code", wr_fault, 3'd2);
        next_edge();
        @(negedge clk);
        check("fault_drain", exp_q.size(), 0);

        // stall_count saturation
        next_edge();
        wr_block = 1'b1;
        set_req(0, 1'b0, 4'd7, 32'h5A5A_5A5A, '0);
        push_exp(1'b0, 4'd7, 32'h5A5A_5A5A, '0);
        next_edge();
        req_valid = '0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("sat_stall", stall_count, 16'hFFFF);
        check("sat_wr_en", wr_en, 0);
        next_edge();
        wr_block = 1'b0;
        @(negedge clk);
        check("sat_release_wr_en", wr_en, 1);
        check("sat_stall_hold", stall_count, 16'hFFFF);
        next_edge();
        @(negedge clk);
        check("sat_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
